// File: rtl/rgb_matrix_driver.sv
`timescale 1ns/1ps
// Scans three 64-bit colour planes into four chained 74HC595s (R, G, B columns, row anode).
// Each row is one 32-bit word shifted MSB first, latched, then the next row follows.
module rgb_matrix_driver (
  input  logic        clk,
  input  logic        reset,
  input  logic        sh_cp,
  input  logic [63:0] red,
  input  logic [63:0] green,
  input  logic [63:0] blue,
  output logic        ds,
  output logic        st_cp,
  output logic        mr_n,
  output logic        oe_n,
  output logic [2:0]  row_idx,
  output logic        frame_done
);

  typedef enum logic [1:0] {CLEAR, SHIFT, LATCH} state_t;

  state_t      state, state_next;
  logic        sh_q, rise, fall;
  logic [5:0]  bit_cnt;
  logic [31:0] word, load_word;
  logic [63:0] red_q, green_q, blue_q;
  logic [2:0]  load_row;
  logic        load, snap, shift, count, latch_set, frame_pulse;

  // Columns are sink-driven, so a lit pixel shifts out as 0.
  function automatic logic [31:0] row_word(input logic [2:0] r, input logic [63:0] rp,
                                           input logic [63:0] gp, input logic [63:0] bp);
    logic [31:0] w;
    w[7:0] = 8'd1 << r;
    for (int c = 0; c < 8; c++) begin
      w[24+c] = ~rp[{r, 3'(c)}];
      w[16+c] = ~gp[{r, 3'(c)}];
      w[8+c]  = ~bp[{r, 3'(c)}];
    end
    return w;
  endfunction

  assign rise = sh_cp & ~sh_q;
  assign fall = ~sh_cp & sh_q;

  // Row 0 is built straight from the inputs because the snapshot is taken in the same clk.
  assign load_word = snap ? row_word(load_row, red, green, blue)
                          : row_word(load_row, red_q, green_q, blue_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load        = 1'b0;
    snap        = 1'b0;
    shift       = 1'b0;
    count       = 1'b0;
    latch_set   = 1'b0;
    frame_pulse = 1'b0;
    load_row    = row_idx;
    unique case (state)
      CLEAR: begin
        if (fall) begin
          state_next = SHIFT;
          load       = 1'b1;
          snap       = 1'b1;
          load_row   = 3'd0;
        end
      end
      SHIFT: begin
        count = rise;
        if (fall) begin
          if (bit_cnt == 6'd32) begin
            latch_set  = 1'b1;
            state_next = LATCH;
          end else begin
            shift = 1'b1;
          end
        end
      end
      LATCH: begin
        if (fall) begin
          state_next  = SHIFT;
          load        = 1'b1;
          load_row    = row_idx + 3'd1;
          snap        = (row_idx == 3'd7);
          frame_pulse = (row_idx == 3'd7);
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q       <= 1'b0;
      bit_cnt    <= 6'd0;
      word       <= 32'd0;
      ds         <= 1'b0;
      st_cp      <= 1'b0;
      mr_n       <= 1'b0;
      oe_n       <= 1'b1;
      row_idx    <= 3'd0;
      frame_done <= 1'b0;
      red_q      <= 64'd0;
      green_q    <= 64'd0;
      blue_q     <= 64'd0;
    end else begin
      sh_q       <= sh_cp;
      frame_done <= frame_pulse;
      if (count) bit_cnt <= bit_cnt + 6'd1;
      if (snap) begin
        red_q   <= red;
        green_q <= green;
        blue_q  <= blue;
      end
      if (load) begin
        word    <= load_word;
        ds      <= load_word[31];
        bit_cnt <= 6'd0;
        row_idx <= load_row;
        st_cp   <= 1'b0;
        mr_n    <= 1'b1;
        oe_n    <= 1'b0;
      end
      if (shift) begin
        word <= {word[30:0], 1'b0};
        ds   <= word[30];
      end
      if (latch_set) st_cp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rgb_matrix_driver.sv
`timescale 1ns/1ps
// Scoreboard bench for rgb_matrix_driver: stimulus queues expected serial bits, latched rows,
// frame pulses and output snapshots; one monitor process pops and compares them.
module tb_rgb_matrix_driver;

  localparam int HALF = 3;

  typedef struct {
    string      name;
    logic       ds;
    logic       st_cp;
    logic       mr_n;
    logic       oe_n;
    logic [2:0] row;
    logic       fd;
  } state_exp_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        sh_cp = 1'b0;
  logic [63:0] red   = '0;
  logic [63:0] green = '0;
  logic [63:0] blue  = '0;
  logic        ds, st_cp, mr_n, oe_n, frame_done;
  logic [2:0]  row_idx;

  logic        bit_q[$];
  logic [2:0]  row_q[$];
  logic        frame_q[$];
  state_exp_t  state_q[$];

  logic [63:0] sr = '0, sg = '0, sb = '0;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          rise_cnt = 0;
  logic        prev_sh = 1'b0, prev_st = 1'b0, prev_fd = 1'b0;
  logic        done = 1'b0;
  state_exp_t  cur;
  logic        exp_bit, tok;
  logic [2:0]  exp_row;
  logic [31:0] w;

  always #5 clk = ~clk;

  rgb_matrix_driver dut (
    .clk        (clk),
    .reset      (reset),
    .sh_cp      (sh_cp),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .ds         (ds),
    .st_cp      (st_cp),
    .mr_n       (mr_n),
    .oe_n       (oe_n),
    .row_idx    (row_idx),
    .frame_done (frame_done)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_state(input string name, input logic e_ds, input logic e_st, input logic e_mr,
                            input logic e_oe, input logic [2:0] e_row, input logic e_fd);
    state_exp_t e;
    e.name = name; e.ds = e_ds; e.st_cp = e_st; e.mr_n = e_mr;
    e.oe_n = e_oe; e.row = e_row; e.fd = e_fd;
    state_q.push_back(e);
  endtask

  function automatic logic [31:0] model_word(input int r);
    logic [31:0] m;
    m = '0;
    m[7:0] = 8'd1 << r;
    for (int c = 0; c < 8; c++) begin
      m[24+c] = ~sr[8*r+c];
      m[16+c] = ~sg[8*r+c];
      m[8+c]  = ~sb[8*r+c];
    end
    return m;
  endfunction

  task automatic sh_period();
    sh_cp = 1'b1;
    repeat (HALF) @(negedge clk);
    sh_cp = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  // One row: 32 shifting periods plus the latch period whose fall loads the next row.
  task automatic run_row(input int r, input logic [31:0] word, input int chg_at, input logic [63:0] chg_green);
    for (int i = 31; i >= 0; i--) bit_q.push_back(word[i]);
    row_q.push_back(3'(r));
    if (r == 7) frame_q.push_back(1'b1);
    for (int p = 0; p < 33; p++) begin
      if (p == chg_at) green = chg_green;
      if (p == 32 && r == 7) begin
        sr = red; sg = green; sb = blue;
      end
      sh_period();
    end
  endtask

  // Monitor: samples 1 time unit after each active clk edge.
  always @(posedge clk) begin
    #1;
    if (state_q.size() != 0) begin
      cur = state_q.pop_front();
      check_output({cur.name, "_ds"},         32'(ds),         32'(cur.ds));
      check_output({cur.name, "_st_cp"},      32'(st_cp),      32'(cur.st_cp));
      check_output({cur.name, "_mr_n"},       32'(mr_n),       32'(cur.mr_n));
      check_output({cur.name, "_oe_n"},       32'(oe_n),       32'(cur.oe_n));
      check_output({cur.name, "_row_idx"},    32'(row_idx),    32'(cur.row));
      check_output({cur.name, "_frame_done"}, 32'(frame_done), 32'(cur.fd));
    end
    if (reset) begin
      rise_cnt = 0;
    end else begin
      if (sh_cp && !prev_sh && mr_n && !st_cp) begin
        rise_cnt++;
        check_output("serial_bit_expected", 32'(bit_q.size() != 0), 32'd1);
        if (bit_q.size() != 0) begin
          exp_bit = bit_q.pop_front();
          check_output("serial_bit", 32'(ds), 32'(exp_bit));
        end
      end
      if (st_cp && !prev_st) begin
        check_output("latch_after_32_rises", 32'(rise_cnt), 32'd32);
        check_output("latch_expected", 32'(row_q.size() != 0), 32'd1);
        if (row_q.size() != 0) begin
          exp_row = row_q.pop_front();
          check_output("latched_row", 32'(row_idx), 32'(exp_row));
        end
        rise_cnt = 0;
      end
      if (frame_done) begin
        check_output("frame_done_row", 32'(row_idx), 32'd0);
        check_output("frame_done_expected", 32'(frame_q.size() != 0), 32'd1);
        if (frame_q.size() != 0) tok = frame_q.pop_front();
      end
      if (prev_fd) check_output("frame_done_width", 32'(frame_done), 32'd0);
    end
    prev_sh = sh_cp;
    prev_st = st_cp;
    prev_fd = frame_done;
    if (done) begin
      check_output("bits_left", 32'(bit_q.size()), 32'd0);
      check_output("rows_left", 32'(row_q.size()), 32'd0);
      check_output("frames_left", 32'(frame_q.size()), 32'd0);
      check_output("states_left", 32'(state_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset release with sh_cp low, then a rise that must be ignored, then the first fall.
    red = 64'h1; green = '0; blue = '0; sh_cp = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    push_state("rst_release", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    repeat (2) @(negedge clk);
    sh_cp = 1'b1;
    push_state("clear_rise", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    repeat (HALF) @(negedge clk);
    sh_cp = 1'b0;
    push_state("clear_fall", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    sr = red; sg = green; sb = blue;
    repeat (HALF) @(negedge clk);

    // Frame 1: single red pixel at row 0 column 0.
    run_row(0, 32'hFEFF_FF01, -1, '0);
    for (int r = 1; r < 7; r++) run_row(r, model_word(r), -1, '0);
    red = '0; blue = '1;
    run_row(7, model_word(7), -1, '0);

    // Frame 2: blue all lit; green flips to all-ones mid row 3 and must stay hidden.
    for (int r = 0; r < 8; r++)
      run_row(r, {24'hFFFF00, 8'd1 << r}, (r == 3) ? 10 : -1, '1);

    // Frame 3: new green visible from row 0; reset lands after the 17th rise of row 2.
    run_row(0, 32'hFF00_0001, -1, '0);
    run_row(1, 32'hFF00_0002, -1, '0);
    w = model_word(2);
    for (int i = 31; i >= 0; i--) bit_q.push_back(w[i]);
    repeat (16) sh_period();
    sh_cp = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    bit_q.delete(); row_q.delete(); frame_q.delete();
    push_state("mid_reset", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    repeat (2) @(negedge clk);

    // Release while sh_cp is still high: nothing may happen until the next fall.
    reset = 1'b0;
    push_state("high_release", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    repeat (2) @(negedge clk);
    push_state("high_hold", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    repeat (2) @(negedge clk);
    sh_cp = 1'b0;
    push_state("high_fall", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    sr = red; sg = green; sb = blue;
    repeat (HALF) @(negedge clk);

    // Frame 4: full frame after the restart.
    run_row(0, 32'hFF00_0001, -1, '0);
    for (int r = 1; r < 8; r++) run_row(r, model_word(r), -1, '0);

    @(negedge clk);
    done = 1'b1;
    repeat (10) @(negedge clk);
    $display("[TB] FAIL monitor_end: summary was not reached");
    $fatal(1, "[TB] monitor did not finish");
  end

endmodule
